ingress_frame_buffer: RTL and testbench
=======================================

# ingress_frame_buffer

Per-port ingress stage that sits directly upstream of the shared-SRAM switch core, one instance per input port. It accepts packets on a sop/eop/vld stream, parses the header word for destination port and priority, admits or drops each whole packet, and buffers admitted packets store-and-forward. It then replays each packet to the switch write interface under a valid/ready handshake, with destination and priority attached.

## Interface
- `NUM_PORTS`, 16, number of switch ports (destination field range)
- `DATA_WIDTH`, 256, stream word width
- `NUM_PRI`, 8, number of priority classes
- `DEPTH`, 64, data buffer depth in words (power of two)
- `DESC_DEPTH`, 4, descriptor FIFO depth in packets (power of two)

- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_sop`  in  1  first word of packet
- `in_eop`  in  1  last word of packet
- `in_vld`  in  1  word valid; no back-pressure on the input side
- `in_data`  in  DATA_WIDTH  packet word
- `dest_full`  in  NUM_PORTS*NUM_PRI  switch full flags; bit `d*NUM_PRI+p` is for port d, priority p
- `out_vld`  out  1  output word valid
- `out_ready`  in  1  switch accepts the word
- `out_sop`  out  1  first word of packet
- `out_eop`  out  1  last word of packet
- `out_data`  out  DATA_WIDTH  packet word
- `out_dest`  out  $clog2(NUM_PORTS)  destination port; held for the whole packet
- `out_pri`  out  $clog2(NUM_PRI)  priority; held for the whole packet
- `pkt_cnt`  out  16  admitted packets; wraps
- `drop_cnt`  out  16  dropped packets; saturates at 0xFFFF

## Operation
- Header is the sop word:
  - dest = `in_data[3:0]`
  - pri = `in_data[6:4]`
  - len = `in_data[15:7]`, the declared length in words including the header
- The header word itself is stored and forwarded unchanged.
- Write side FSM has three states: IDLE, RECV, DROP.
- In IDLE:
  - A word with vld=1 and sop=0 is ignored and not counted.
  - When vld&sop arrives, the packet is admitted iff all of the following hold:
    - len != 0
    - len <= DEPTH
    - free words >= len
    - `dest_full[dest*NUM_PRI+pri]` == 0
    - the descriptor FIFO is not full
  - On admit, the header is written and the FSM goes to RECV. On reject, the FSM goes to DROP.
  - A single-word packet (sop&eop) that is admitted commits immediately and stays in IDLE. If rejected, it counts a drop and stays in IDLE.
- RECV writes each vld word at the speculative write pointer `wr_spec`. The committed pointer `wr_cmt` does not move yet.
  - eop with word count == len: set `wr_cmt` = `wr_spec`+1, push descriptor {dest, pri, len}, increment pkt_cnt, go to IDLE.
  - Word count would exceed len, or eop arrives with count < len: roll back `wr_spec` = `wr_cmt`, increment drop_cnt. Go to IDLE, or to DROP if eop has not yet arrived.
  - sop while in RECV: abort the current packet (rollback, drop_cnt+1), then treat this word as a new header in the same cycle.
- DROP discards words until vld&eop, then goes to IDLE. Drop is counted once per packet, on entry. A sop in DROP is handled like a new header in IDLE.
- Free words = DEPTH − (`wr_spec` − `rd_ptr`), computed in $clog2(DEPTH)+1 bits, modulo arithmetic. Pointers wrap.
- Read side pops descriptors in order and streams len words from `rd_ptr`.
  - out_sop on the first word, out_eop on the len-th word.
  - out_dest and out_pri are taken from the descriptor.
  - A word transfers when out_vld & out_ready; `rd_ptr` advances only on transfer.

## Timing
- Reset values: all outputs 0, pointers 0, FSM in IDLE, descriptor FIFO empty.
- Reset mid-packet discards everything, with no count.
- Store-and-forward: out_vld rises earliest 1 cycle after the eop write that commits the packet. Data is registered; no combinational in→out path.
- Back-to-back packets: the sop of the next packet may be presented the cycle after the previous out_eop transfer (no bubble).
- out_vld, out_data, out_sop, out_eop, out_dest and out_pri are stable while out_vld & !out_ready.
- out_vld never deasserts mid-packet.
- Simultaneous write commit and read pop in one cycle are both honoured.
- `dest_full` is sampled only on the sop cycle. Later changes do not affect an admitted packet.

## Structure
- Package `ingress_pkg`:
  - header field offsets and widths (DEST_LSB, PRI_LSB, LEN_LSB, LEN_W)
  - write FSM state enum
  - descriptor struct {dest, pri, len}
- Sub-module `desc_fifo`: a synchronous FIFO of DESC_DEPTH descriptors with full/empty. Data buffer, FSM and read sequencer stay in `ingress_frame_buffer`.

## Test plan
- Single 4-word packet, dest=5, pri=2, len=4, out_ready=1 → 4 output words identical to input, out_sop on word 1, out_eop on word 4, out_dest=5, out_pri=2, first out_vld 1 cycle after eop, pkt_cnt=1.
- `dest_full[5*8+2]`=1 at sop → no output, drop_cnt=1. The next packet to dest=3 passes.
- Header len=4 but eop on word 6 → packet dropped, buffer free returns to 64, drop_cnt=1. A following 2-word packet is forwarded correctly.
- Fill: out_ready=0, send 16 packets of len=4 → only DESC_DEPTH=4 are admitted, 12 dropped. Release out_ready → exactly 4 packets out, in order.
- sop asserted mid-packet in RECV → first packet dropped, second forwarded intact.
- Output stall: toggle out_ready randomly during a 64-word packet → words delivered in order, with outputs held stable during stalls.

Source files
------------

// File: rtl/ingress_pkg.sv
// Shared definitions for the per-port ingress frame buffer.
// Header field layout of the sop word, write-side FSM states and
// the per-packet descriptor carried from the write side to the read side.
package ingress_pkg;

    // Header word layout: dest in [3:0], pri in [6:4], len in [15:7]
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 4;
    localparam int PRI_LSB  = 4;
    localparam int PRI_W    = 3;
    localparam int LEN_LSB  = 7;
    localparam int LEN_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [PRI_W-1:0]  pri;
        logic [LEN_W-1:0]  len;
    } desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO of packet descriptors with full/empty flags.
// Ports: push/push_data write side, pop/pop_data read side (show-ahead head),
// full/empty status. Push when full and pop when empty are ignored.
module desc_fifo
    import ingress_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  desc_t push_data,
    input  logic  pop,
    output desc_t pop_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    desc_t         mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty    = (wp == rp);
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ingress_frame_buffer.sv
// Per-port ingress stage: parses the sop header (dest/pri/len), admits or
// drops whole packets, stores admitted packets store-and-forward and replays
// them to the switch under valid/ready with dest/pri attached.
// Ports: in_* stream (no back-pressure), dest_full per (port,pri) flags,
// out_* stream with out_ready, pkt_cnt (wraps) and drop_cnt (saturates).
module ingress_frame_buffer
    import ingress_pkg::*;
#(
    parameter int NUM_PORTS  = 16,
    parameter int DATA_WIDTH = 256,
    parameter int NUM_PRI    = 8,
    parameter int DEPTH      = 64,
    parameter int DESC_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_sop,
    input  logic                         in_eop,
    input  logic                         in_vld,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [NUM_PORTS*NUM_PRI-1:0] dest_full,
    output logic                         out_vld,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_PORTS)-1:0] out_dest,
    output logic [$clog2(NUM_PRI)-1:0]   out_pri,
    output logic [15:0]                  pkt_cnt,
    output logic [15:0]                  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(NUM_PORTS);
    localparam int QW = $clog2(NUM_PRI);
    localparam int FW = $clog2(NUM_PORTS*NUM_PRI);
    localparam int CW = LEN_W + 2;
    localparam int OW = $clog2(DESC_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write side state
    wr_state_t         state, nxt_state;
    logic [PW-1:0]     wr_spec, wr_cmt, nxt_spec, nxt_cmt;
    logic [LEN_W-1:0]  cnt, nxt_cnt, cnt_inc, cur_len;
    logic [DEST_W-1:0] cur_dest;
    logic [PRI_W-1:0]  cur_pri;
    logic [OW-1:0]     pend_cnt;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic              push;
    desc_t             push_desc;
    logic              pkt_inc;
    logic [1:0]        drop_add;
    logic              hdr_take;
    logic [16:0]       drop_sum;

    // Read side state
    logic [PW-1:0]     rd_ptr, rd_next;
    logic [LEN_W-1:0]  rd_left;
    desc_t             head;
    logic              desc_full, desc_empty;
    logic              xfer, last_xfer, load_sop;

    // Header decode
    logic [DEST_W-1:0] hdr_dest;
    logic [PRI_W-1:0]  hdr_pri;
    logic [LEN_W-1:0]  hdr_len;
    logic [FW-1:0]     full_idx;
    logic [PW-1:0]     hdr_free;
    logic              hdr_ok;

    assign hdr_dest = in_data[DEST_LSB +: DEST_W];
    assign hdr_pri  = in_data[PRI_LSB +: PRI_W];
    assign hdr_len  = in_data[LEN_LSB +: LEN_W];
    assign full_idx = FW'(hdr_dest) * FW'(NUM_PRI) + FW'(hdr_pri);

    // Free space is measured from the committed pointer: a header seen in
    // RECV aborts the packet in flight, so its speculative words are free.
    // Outside RECV wr_spec equals wr_cmt, so this is the same value.
    assign hdr_free = PW'(DEPTH) - (wr_cmt - rd_ptr);

    // pend_cnt counts committed packets not yet fully sent, including the
    // one whose descriptor is already popped into the output stage, so the
    // packet limit covers every packet still occupying the buffer.
    assign hdr_ok = (hdr_len != '0)
                 && (CW'(hdr_len) <= CW'(DEPTH))
                 && (CW'(hdr_free) >= CW'(hdr_len))
                 && !dest_full[full_idx]
                 && !desc_full
                 && (pend_cnt < OW'(DESC_DEPTH));

    always_comb begin
        nxt_state      = state;
        nxt_spec       = wr_spec;
        nxt_cmt        = wr_cmt;
        nxt_cnt        = cnt;
        cnt_inc        = cnt + LEN_W'(1);
        mem_we         = 1'b0;
        mem_waddr      = wr_spec[AW-1:0];
        push           = 1'b0;
        push_desc.dest = cur_dest;
        push_desc.pri  = cur_pri;
        push_desc.len  = cur_len;
        pkt_inc        = 1'b0;
        drop_add       = 2'd0;
        hdr_take       = 1'b0;

        if (in_vld) begin
            if (in_sop) begin
                // A header in RECV aborts the packet in flight, then is
                // evaluated exactly like a header seen in IDLE or DROP.
                if (state == ST_RECV) drop_add = 2'd1;
                nxt_spec = wr_cmt;
                if (hdr_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_cmt[AW-1:0];
                    if (in_eop) begin
                        if (hdr_len == LEN_W'(1)) begin
                            nxt_spec       = wr_cmt + PW'(1);
                            nxt_cmt        = wr_cmt + PW'(1);
                            push           = 1'b1;
                            push_desc.dest = hdr_dest;
                            push_desc.pri  = hdr_pri;
                            push_desc.len  = hdr_len;
                            pkt_inc        = 1'b1;
                        end else begin
                            // single word but declared longer: short packet
                            drop_add = drop_add + 2'd1;
                        end
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_spec  = wr_cmt + PW'(1);
                        nxt_cnt   = LEN_W'(1);
                        hdr_take  = 1'b1;
                        nxt_state = ST_RECV;
                    end
                end else begin
                    drop_add  = drop_add + 2'd1;
                    nxt_state = in_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state)
                    ST_RECV: begin
                        if (cnt == cur_len) begin
                            // one word more than declared
                            nxt_spec  = wr_cmt;
                            drop_add  = 2'd1;
                            nxt_state = in_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            nxt_spec = wr_spec + PW'(1);
                            nxt_cnt  = cnt_inc;
                            if (in_eop) begin
                                nxt_state = ST_IDLE;
                                if (cnt_inc == cur_len) begin
                                    nxt_cmt = wr_spec + PW'(1);
                                    push    = 1'b1;
                                    pkt_inc = 1'b1;
                                end else begin
                                    nxt_spec = wr_cmt;
                                    drop_add = 2'd1;
                                end
                            end
                        end
                    end
                    ST_DROP: begin
                        if (in_eop) nxt_state = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_add);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_spec  <= '0;
            wr_cmt   <= '0;
            cnt      <= '0;
            cur_len  <= '0;
            cur_dest <= '0;
            cur_pri  <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            pend_cnt <= '0;
        end else begin
            state   <= nxt_state;
            wr_spec <= nxt_spec;
            wr_cmt  <= nxt_cmt;
            cnt     <= nxt_cnt;
            if (hdr_take) begin
                cur_len  <= hdr_len;
                cur_dest <= hdr_dest;
                cur_pri  <= hdr_pri;
            end
            pkt_cnt  <= pkt_cnt + 16'(pkt_inc);
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case ({push, last_xfer})
                2'b10:   pend_cnt <= pend_cnt + OW'(1);
                2'b01:   pend_cnt <= pend_cnt - OW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= in_data;
    end

    desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_desc),
        .pop       (load_sop),
        .pop_data  (head),
        .full      (desc_full),
        .empty     (desc_empty)
    );

    // Read sequencer: the output register always holds the word at rd_ptr.
    // A new packet's header is loaded either into an empty output stage or
    // directly behind an eop transfer, so consecutive packets leave
    // without a bubble.
    assign xfer      = out_vld && out_ready;
    assign last_xfer = xfer && out_eop;
    assign load_sop  = !desc_empty && (!out_vld || last_xfer);
    assign rd_next   = rd_ptr + PW'(xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_left  <= '0;
            out_vld  <= 1'b0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_data <= '0;
            out_dest <= '0;
            out_pri  <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (load_sop) begin
                out_vld  <= 1'b1;
                out_sop  <= 1'b1;
                out_eop  <= (head.len == LEN_W'(1));
                out_data <= mem[rd_next[AW-1:0]];
                out_dest <= DW'(head.dest);
                out_pri  <= QW'(head.pri);
                rd_left  <= head.len - LEN_W'(1);
            end else if (last_xfer) begin
                out_vld <= 1'b0;
                out_sop <= 1'b0;
                out_eop <= 1'b0;
            end else if (xfer) begin
                out_sop  <= 1'b0;
                out_eop  <= (rd_left == LEN_W'(1));
                out_data <= mem[rd_next[AW-1:0]];
                rd_left  <= rd_left - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ingress_frame_buffer.sv
module tb_ingress_frame_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_sop, in_eop, in_vld;
    logic [255:0] in_data;
    logic [127:0] dest_full;
    logic         out_vld, out_ready, out_sop, out_eop;
    logic [255:0] out_data;
    logic [3:0]   out_dest;
    logic [2:0]   out_pri;
    logic [15:0]  pkt_cnt, drop_cnt;

    ingress_frame_buffer dut (
        .clk(clk), .rst(rst), .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld),
        .in_data(in_data), .dest_full(dest_full), .out_vld(out_vld),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_dest(out_dest), .out_pri(out_pri),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   dest;
        logic [2:0]   pri;
        int           cyc;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stab_err = 0;
    int   gap_err = 0;

    // Output monitor, sampled on the falling edge
    logic         hold_pend = 1'b0;
    logic         in_pkt = 1'b0;
    rec_t         held;
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pend && (out_vld !== 1'b1 || out_data !== held.data || out_sop !== held.sop ||
                              out_eop !== held.eop || out_dest !== held.dest || out_pri !== held.pri))
                stab_err++;
            if (in_pkt && out_vld !== 1'b1) gap_err++;
            hold_pend = out_vld && !out_ready;
            held.data = out_data; held.sop = out_sop; held.eop = out_eop;
            held.dest = out_dest; held.pri = out_pri; held.cyc = cyc;
            if (out_vld && out_ready) begin
                got_q.push_back(held);
                if (out_sop && !out_eop) in_pkt = 1'b1;
                if (out_eop) in_pkt = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_hdr(input int dest, input int pri, input int len, input int tag);
        logic [255:0] d;
        d = '0;
        d[3:0]     = dest[3:0];
        d[6:4]     = pri[2:0];
        d[15:7]    = len[8:0];
        d[255:240] = tag[15:0];
        return d;
    endfunction

    function automatic logic [255:0] mk_pay(input int tag, input int i);
        logic [255:0] d;
        d = {8{32'hC0DE0000 + i[31:0]}};
        d[255:240] = tag[15:0];
        return d;
    endfunction

    // Sends one packet; the expected output stream is appended when it should pass.
    task automatic send_pkt(input int dest, input int pri, input int len, input int nwords,
                            input int tag, input bit expect_out, output int eop_cyc);
        rec_t r;
        for (int i = 0; i < nwords; i++) begin
            in_vld  = 1'b1;
            in_sop  = (i == 0);
            in_eop  = (i == nwords - 1);
            in_data = (i == 0) ? mk_hdr(dest, pri, len, tag) : mk_pay(tag, i);
            if (expect_out) begin
                r.data = in_data; r.sop = in_sop; r.eop = in_eop;
                r.dest = dest[3:0]; r.pri = pri[2:0]; r.cyc = 0;
                exp_q.push_back(r);
            end
            tick();
        end
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        eop_cyc = cyc;
    endtask

    task automatic wait_drain(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, required %0d", name, got_q.size(), n);
        end
    endtask

    // Number of words differing from the expected stream (-1 on length mismatch)
    function automatic int stream_mismatch();
        int n;
        n = 0;
        if (got_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i])
            if (got_q[i].data !== exp_q[i].data || got_q[i].sop !== exp_q[i].sop ||
                got_q[i].eop !== exp_q[i].eop || got_q[i].dest !== exp_q[i].dest ||
                got_q[i].pri !== exp_q[i].pri)
                n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        dest_full = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
        hold_pend = 1'b0; in_pkt = 1'b0; stab_err = 0; gap_err = 0;
        tick();
    endtask

    task automatic check_counts(input string name, input int pk, input int dr);
        checks++;
        if (pkt_cnt !== 16'(pk)) begin
            errors++; $display("FAIL %s pkt_cnt: got %0d, required %0d", name, pkt_cnt, pk);
        end
        checks++;
        if (drop_cnt !== 16'(dr)) begin
            errors++; $display("FAIL %s drop_cnt: got %0d, required %0d", name, drop_cnt, dr);
        end
    endtask

    task automatic check_stream(input string name);
        int n;
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL %s words: got %0d, required %0d", name, got_q.size(), exp_q.size());
        end
        n = stream_mismatch();
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL %s content: %0d bad words, required 0", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
        in_data = mk_hdr(1, 1, 4, 9); dest_full = '0; out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_vld, out_sop, out_eop} !== 3'b000) begin
            errors++; $display("FAIL reset flags: got %b, required 000", {out_vld, out_sop, out_eop});
        end
        checks++;
        if (out_data !== '0 || out_dest !== 4'd0 || out_pri !== 3'd0) begin
            errors++; $display("FAIL reset data: got dest %0d pri %0d, required 0/0 and zero data", out_dest, out_pri);
        end
        check_counts("reset", 0, 0);
        do_reset();
    endtask

    task automatic test_single();
        int e;
        do_reset();
        send_pkt(5, 2, 4, 4, 16'h11, 1'b1, e);
        wait_drain(4, 50, "single");
        check_stream("single");
        checks++;
        if (got_q.size() > 0 && got_q[0].cyc !== e + 1) begin
            errors++; $display("FAIL single latency: first out cycle %0d, required %0d", got_q[0].cyc, e + 1);
        end
        check_counts("single", 1, 0);
    endtask

    task automatic test_dest_full();
        int e;
        do_reset();
        dest_full[5*8+2] = 1'b1;
        send_pkt(5, 2, 4, 4, 16'h21, 1'b0, e);
        dest_full[5*8+2] = 1'b0;   // change after sop must not matter
        repeat (10) tick();
        checks++;
        if (got_q.size() !== 0) begin
            errors++; $display("FAIL dest_full blocked: got %0d words, required 0", got_q.size());
        end
        dest_full[5*8+2] = 1'b1;
        send_pkt(3, 2, 3, 3, 16'h22, 1'b1, e);
        wait_drain(3, 50, "dest_full");
        check_stream("dest_full");
        check_counts("dest_full", 1, 1);
    endtask

    task automatic test_length();
        int e;
        do_reset();
        send_pkt(1, 0, 4, 6, 16'h31, 1'b0, e);   // too long
        check_counts("len_long", 0, 1);
        send_pkt(1, 0, 4, 2, 16'h32, 1'b0, e);   // too short
        send_pkt(1, 0, 0, 2, 16'h33, 1'b0, e);   // zero length
        send_pkt(1, 0, 65, 2, 16'h34, 1'b0, e);  // larger than buffer
        check_counts("len_bad", 0, 4);
        // full-depth packet only fits if all rolled-back space was returned
        send_pkt(7, 6, 64, 64, 16'h35, 1'b1, e);
        wait_drain(64, 200, "len_full");
        send_pkt(2, 1, 2, 2, 16'h36, 1'b1, e);
        send_pkt(9, 7, 1, 1, 16'h37, 1'b1, e);   // single-word packet
        wait_drain(67, 100, "len_tail");
        check_stream("length");
        check_counts("length", 3, 4);
    endtask

    task automatic test_fill();
        int e;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send_pkt(k % 16, k % 8, 4, 4, 16'h100 + k, k < 4, e);
        repeat (5) tick();
        check_counts("fill", 4, 12);
        checks++;
        if (got_q.size() !== 0) begin
            errors++; $display("FAIL fill stalled: got %0d words, required 0", got_q.size());
        end
        out_ready = 1'b1;
        wait_drain(16, 200, "fill");
        repeat (20) tick();
        check_stream("fill");
        checks++;
        if (stab_err !== 0) begin
            errors++; $display("FAIL fill hold: %0d unstable samples, required 0", stab_err);
        end
    endtask

    task automatic test_mid_sop();
        int e;
        do_reset();
        in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = mk_hdr(4, 3, 4, 16'h41); tick();
        in_sop = 1'b0; in_data = mk_pay(16'h41, 1); tick();
        send_pkt(6, 5, 3, 3, 16'h42, 1'b1, e);
        wait_drain(3, 50, "mid_sop");
        repeat (5) tick();
        check_stream("mid_sop");
        check_counts("mid_sop", 1, 1);
    endtask

    task automatic test_reset_mid();
        int e;
        do_reset();
        in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = mk_hdr(4, 3, 4, 16'h51); tick();
        in_sop = 1'b0; in_data = mk_pay(16'h51, 1); tick();
        do_reset();
        check_counts("reset_mid", 0, 0);
        send_pkt(8, 4, 2, 2, 16'h52, 1'b1, e);
        wait_drain(2, 50, "reset_mid");
        check_stream("reset_mid");
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        send_pkt(10, 1, 3, 3, 16'h61, 1'b1, e);
        send_pkt(11, 2, 3, 3, 16'h62, 1'b1, e);
        wait_drain(6, 50, "b2b");
        check_stream("b2b");
        checks++;
        if (got_q.size() >= 4 && got_q[3].cyc !== got_q[2].cyc + 1) begin
            errors++; $display("FAIL b2b bubble: second sop cycle %0d, required %0d", got_q[3].cyc, got_q[2].cyc + 1);
        end
        check_counts("b2b", 2, 0);
    endtask

    task automatic test_stall();
        int e;
        int k;
        do_reset();
        send_pkt(12, 3, 64, 64, 16'h71, 1'b1, e);
        k = 0;
        while (got_q.size() < 64 && k < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        out_ready = 1'b1;
        wait_drain(64, 20, "stall");
        check_stream("stall");
        checks++;
        if (stab_err !== 0) begin
            errors++; $display("FAIL stall hold: %0d unstable samples, required 0", stab_err);
        end
        checks++;
        if (gap_err !== 0) begin
            errors++; $display("FAIL stall gap: %0d mid-packet valid drops, required 0", gap_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dest_full();
        test_length();
        test_fill();
        test_mid_sop();
        test_reset_mid();
        test_back_to_back();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
